// File: rtl/matmul_sequencer.sv
// Sequencer driving a 3x3 MAC-array multiplier: CLEAR, 3 FEED beats, SETTLE idle, 9 UNLOAD captures.
// Latency: done pulses in cycle T+14+SETTLE after the start-accept edge T (15 cycles with SETTLE=1).
// Backpressure: none; start and operand writes are dropped while busy. Optional checksum port: MATSEQ_CHECKSUM_EN.
module matmul_sequencer #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 10,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              result_valid,
    input  logic [3:0]        rd_addr,
    output logic [RES_W-1:0]  rd_data,
    output logic [DATA_W-1:0] mm_w1,
    output logic [DATA_W-1:0] mm_w2,
    output logic [DATA_W-1:0] mm_w3,
    output logic [DATA_W-1:0] mm_x1,
    output logic [DATA_W-1:0] mm_x2,
    output logic [DATA_W-1:0] mm_x3,
    output logic [8:0]        mm_load,
    output logic [8:0]        mm_clear,
    output logic              mm_unload_res,
    input  logic [RES_W-1:0]  mm_data_out
`ifdef MATSEQ_CHECKSUM_EN
    ,
    output logic [RES_W+3:0]  checksum
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] w_q [9];
    logic [DATA_W-1:0] x_q [9];
    logic [RES_W-1:0]  c_q [9];
    logic              busy_q, done_q, rv_q, unload_q;
    logic [8:0]        load_q, clear_q;
    logic [DATA_W-1:0] opw_q [3];
    logic [DATA_W-1:0] opx_q [3];
    logic [DATA_W-1:0] opw_d [3];
    logic [DATA_W-1:0] opx_d [3];
    logic              accept, wr_ok, capture;

    assign accept  = (state_q == S_IDLE) && start;
    assign wr_ok   = (state_q == S_IDLE) && wr_en && (wr_addr <= 4'd8);
    assign capture = (state_q == S_UNLOAD);

    // Next-state and per-phase beat counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CLEAR;
                cnt_d   = 4'd0;
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = 4'd0;
            end
            S_FEED: if (cnt_q == 4'd2) begin
                state_d = S_SETTLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            S_SETTLE: if (cnt_q == 4'(SETTLE - 1)) begin
                state_d = S_UNLOAD;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            S_UNLOAD: if (cnt_q == 4'd8) begin
                state_d = S_DONE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Operands for the coming cycle: row i of W and row k of X, selected by the next FEED beat.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            opw_d[i] = '0;
            opx_d[i] = '0;
        end
        if (state_d == S_FEED) begin
            for (int i = 0; i < 3; i++) begin
                opw_d[i] = w_q[4'(i * 3) + cnt_d];
                opx_d[i] = x_q[cnt_d * 4'd3 + 4'(i)];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand storage (IDLE-only writes) and result capture during UNLOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 9; n++) begin
                w_q[n] <= '0;
                x_q[n] <= '0;
                c_q[n] <= '0;
            end
        end else begin
            if (wr_ok && !wr_sel) w_q[wr_addr] <= wr_data;
            if (wr_ok &&  wr_sel) x_q[wr_addr] <= wr_data;
            if (capture)          c_q[cnt_q]   <= mm_data_out;
        end
    end

    // Registered outputs, decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            unload_q <= 1'b0;
            load_q   <= '0;
            clear_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                opw_q[i] <= '0;
                opx_q[i] <= '0;
            end
        end else begin
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
            unload_q <= (state_d == S_UNLOAD);
            load_q   <= {9{state_d == S_FEED}};
            clear_q  <= {9{state_d == S_CLEAR}};
            if (state_d == S_DONE)       rv_q <= 1'b1;
            else if (state_d == S_CLEAR) rv_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                opw_q[i] <= opw_d[i];
                opx_q[i] <= opx_d[i];
            end
        end
    end

`ifdef MATSEQ_CHECKSUM_EN
    logic [RES_W+3:0] checksum_q;

    // Running sum of captured results, restarted at each accepted start.
    always_ff @(posedge clk) begin
        if (rst)          checksum_q <= '0;
        else if (accept)  checksum_q <= '0;
        else if (capture) checksum_q <= checksum_q + {4'b0, mm_data_out};
    end

    assign checksum = checksum_q;
`endif

    // Combinational result read; out-of-range indices read as zero.
    always_comb begin
        rd_data = '0;
        if (rd_addr <= 4'd8) rd_data = c_q[rd_addr];
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign result_valid  = rv_q;
    assign mm_load       = load_q;
    assign mm_clear      = clear_q;
    assign mm_unload_res = unload_q;
    assign mm_w1         = opw_q[0];
    assign mm_w2         = opw_q[1];
    assign mm_w3         = opw_q[2];
    assign mm_x1         = opx_q[0];
    assign mm_x2         = opx_q[1];
    assign mm_x3         = opx_q[2];

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a behavioural MAC-array stands in for the multiplier.
// Expected timelines and products come from plain matrix arithmetic over the written operands.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_matmul_sequencer;

    localparam int SETTLE = 1;
    localparam int L_DONE = 1 + 1 + 3 + SETTLE + 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
    logic [3:0]  wr_addr = 4'd0, wr_data = 4'd0, rd_addr = 4'd0;
    logic        busy, done, result_valid, mm_unload_res;
    logic [9:0]  rd_data, mm_data_out;
    logic [3:0]  mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3;
    logic [8:0]  mm_load, mm_clear;
`ifdef MATSEQ_CHECKSUM_EN
    logic [13:0] checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mw [9];
    int mx [9];

    always #5 clk = ~clk;

    matmul_sequencer #(.DATA_W(4), .RES_W(10), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .result_valid(result_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .mm_w1(mm_w1), .mm_w2(mm_w2), .mm_w3(mm_w3),
        .mm_x1(mm_x1), .mm_x2(mm_x2), .mm_x3(mm_x3),
        .mm_load(mm_load), .mm_clear(mm_clear), .mm_unload_res(mm_unload_res),
        .mm_data_out(mm_data_out)
`ifdef MATSEQ_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Behavioural 3x3 MAC array: MAC m=i*3+j accumulates w(i)*x(j); results stream out row-major.
    logic [9:0] acc [9];
    logic [3:0] uidx;
    logic [9:0] ow [3];
    logic [9:0] ox [3];
    assign ow[0] = {6'b0, mm_w1};
    assign ow[1] = {6'b0, mm_w2};
    assign ow[2] = {6'b0, mm_w3};
    assign ox[0] = {6'b0, mm_x1};
    assign ox[1] = {6'b0, mm_x2};
    assign ox[2] = {6'b0, mm_x3};
    assign mm_data_out = (mm_unload_res && uidx < 4'd9) ? acc[uidx] : 10'd0;

    always @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 9; m++) acc[m] <= 10'd0;
            uidx <= 4'd0;
        end else begin
            for (int m = 0; m < 9; m++) begin
                if (mm_clear[m])     acc[m] <= 10'd0;
                else if (mm_load[m]) acc[m] <= acc[m] + ow[m / 3] * ox[m % 3];
            end
            uidx <= mm_unload_res ? uidx + 4'd1 : 4'd0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cref(input int n);
        int s = 0;
        for (int k = 0; k < 3; k++) s += mw[(n / 3) * 3 + k] * mx[k * 3 + (n % 3)];
        return s;
    endfunction

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = 4'(data);
        if (addr <= 8) begin
            if (sel) mx[addr] = data;
            else     mw[addr] = data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int n = 0; n < 9; n++) begin
            rd_addr = 4'(n);
            #1;
            check(tag, 64'(rd_data), 64'(cref(n)));
        end
        rd_addr = 4'd9;
        #1;
        check("rd_addr9_zero", 64'(rd_data), 64'd0);
        rd_addr = 4'd0;
    endtask

    // One multiply run; optionally a same-cycle operand write with start, and noise start/writes while busy.
    task automatic run(input string tag, input bit noise, input bit wr_same, input int waddr, input int wdata);
        logic [21:0] ctl_e;
        logic [23:0] op_e;
        int          sum;
        start = 1'b1;
        if (wr_same) begin
            wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'(waddr); wr_data = 4'(wdata);
            mx[waddr] = wdata;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        for (int s = 1; s <= L_DONE + 1; s++) begin
            ctl_e = {s <= L_DONE, s == L_DONE, s >= L_DONE,
                     (s >= 5 + SETTLE) && (s <= 13 + SETTLE),
                     {9{(s >= 2) && (s <= 4)}}, {9{s == 1}}};
            check({tag, "_ctl"}, 64'({busy, done, result_valid, mm_unload_res, mm_load, mm_clear}), 64'(ctl_e));
            op_e = '0;
            if (s >= 2 && s <= 4) begin
                op_e = {4'(mw[0 + s - 2]), 4'(mw[3 + s - 2]), 4'(mw[6 + s - 2]),
                        4'(mx[(s - 2) * 3]), 4'(mx[(s - 2) * 3 + 1]), 4'(mx[(s - 2) * 3 + 2])};
            end
            check({tag, "_ops"}, 64'({mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3}), 64'(op_e));
            if (noise && s <= 13) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'($urandom);
                wr_addr = 4'($urandom_range(0, 8)); wr_data = 4'($urandom);
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
        end
        sum = 0;
        for (int n = 0; n < 9; n++) sum += cref(n);
`ifdef MATSEQ_CHECKSUM_EN
        check({tag, "_checksum"}, 64'(checksum), 64'(sum));
`endif
        read_all({tag, "_C"});
    endtask

    initial begin
        bit saw_done;
        for (int n = 0; n < 9; n++) begin mw[n] = 0; mx[n] = 0; end
        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({busy, done, result_valid, mm_unload_res, mm_load, mm_clear}), 64'd0);
        check("reset_ops", 64'({mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3}), 64'd0);
`ifdef MATSEQ_CHECKSUM_EN
        check("reset_checksum", 64'(checksum), 64'd0);
`endif
        read_all("reset_C");
        rst = 1'b0;
        @(negedge clk);

        // Identity W times X=1..9; last X element written in the start cycle.
        for (int n = 0; n < 9; n++) wr(1'b0, n, (n % 4 == 0) ? 1 : 0);
        for (int n = 0; n < 8; n++) wr(1'b1, n, n + 1);
        wr(1'b1, 12, 7);
        run("ident", 1'b0, 1'b1, 8, 9);

        // All-15 operands: every product sums to 675.
        for (int n = 0; n < 9; n++) begin wr(1'b0, n, 15); wr(1'b1, n, 15); end
        run("max", 1'b0, 1'b0, 0, 0);

        // Random operands with start/write noise while busy, then a clean rerun on the same operands.
        for (int n = 0; n < 9; n++) begin
            wr(1'b0, n, int'($urandom_range(0, 15)));
            wr(1'b1, n, int'($urandom_range(0, 15)));
        end
        run("noise", 1'b1, 1'b0, 0, 0);
        run("rerun", 1'b0, 1'b0, 0, 0);

        for (int t = 0; t < 2; t++) begin
            for (int n = 0; n < 9; n++) begin
                wr(1'b0, n, int'($urandom_range(0, 15)));
                wr(1'b1, n, int'($urandom_range(0, 15)));
            end
            run("rand", 1'b0, 1'b0, 0, 0);
        end

        // Zero W: all results and the checksum are zero.
        for (int n = 0; n < 9; n++) wr(1'b0, n, 0);
        run("wzero", 1'b0, 1'b0, 0, 0);

        // Reset in FEED beat k=1 aborts the run and clears the buffers.
        for (int n = 0; n < 9; n++) begin
            wr(1'b0, n, int'($urandom_range(1, 15)));
            wr(1'b1, n, int'($urandom_range(1, 15)));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_k1_w2", 64'(mm_w2), 64'(mw[4]));
        check("abort_k1_x3", 64'(mm_x3), 64'(mx[5]));
        rst = 1'b1;
        for (int n = 0; n < 9; n++) begin mw[n] = 0; mx[n] = 0; end
        @(negedge clk);
        check("abort_ctl", 64'({busy, done, result_valid, mm_unload_res, mm_load, mm_clear}), 64'd0);
        check("abort_ops", 64'({mm_w1, mm_w2, mm_w3, mm_x1, mm_x2, mm_x3}), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_rv", 64'(result_valid), 64'd0);
        read_all("abort_C");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Initiator/controller for the 3x3 MAC-array matrix multiplier; drives its operand, load, clear and unload inputs and collects the serialized 10-bit results.
- Host writes two 3x3 matrices of 4-bit unsigned elements, W and X, pulses start, and reads back C = W x X from a 9-entry result buffer.
- Sits between the host register interface and the multiplier array.

Parameters:
- DATA_W, 4, operand element width
- RES_W, 10, result element width; must match the multiplier output
- SETTLE, 1, idle cycles between the last load and the start of unload; range 1..7

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  operand write strobe
- wr_sel  in  1  target matrix: 0=W, 1=X
- wr_addr  in  4  element index 0..8, row-major (r*3+c)
- wr_data  in  DATA_W  element value
- start  in  1  begin a multiply
- busy  out  1  high from start accept through DONE
- done  out  1  one-cycle pulse at completion
- result_valid  out  1  result buffer holds a complete C
- rd_addr  in  4  result index 0..8, row-major
- rd_data  out  RES_W  combinational C[rd_addr]
- mm_w1, mm_w2, mm_w3  out  DATA_W  row operands to the array
- mm_x1, mm_x2, mm_x3  out  DATA_W  column operands to the array
- mm_load  out  9  per-MAC accumulate enable
- mm_clear  out  9  per-MAC accumulator clear
- mm_unload_res  out  1  result unload enable
- mm_data_out  in  RES_W  serialized result from the array

Behaviour:
- Reset: FSM goes to IDLE. W, X and the result buffer are zeroed. All outputs are 0, including busy, done, result_valid, every mm_* output and rd_data.
- Reset asserted mid-operation aborts the run. All outputs return to 0 on the next edge. No done pulse is produced.
- Writes: accepted only in IDLE. Writes with wr_addr>8, or writes while busy, are ignored. A write and a start in the same IDLE cycle both take effect, and the run uses the newly written value.
- FSM states: IDLE, CLEAR, FEED, SETTLE, UNLOAD, DONE.
- IDLE: on start, go to CLEAR. busy=1 and result_valid=0 from the next cycle. start outside IDLE is ignored.
- CLEAR: 1 cycle. mm_clear=9'h1FF, mm_load=0.
- FEED: 3 cycles, k=0,1,2. mm_load=9'h1FF, mm_clear=0. Operands are mm_w{i+1}=W[i][k] and mm_x{j+1}=X[k][j].
- SETTLE: SETTLE cycles. mm_load=0.
- UNLOAD: 9 cycles, n=0..8. mm_unload_res=1. On the clock edge ending cycle n, mm_data_out is captured into C[n].
- DONE: 1 cycle. done=1, busy=1, result_valid set. Next state is IDLE; busy drops in IDLE.
- Latency: start accepted at edge T gives done high in cycle T+1+1+3+SETTLE+9. With SETTLE=1 that is 15 cycles after the accept edge.
- Operand outputs mm_w*/mm_x* are 0 outside FEED. mm_load, mm_clear and mm_unload_res are 0 outside their states.
- All mm_* outputs and busy/done/result_valid are registered; no combinational path exists from inputs to them.
- rd_data: combinational read of C. Returns 0 for rd_addr>8.
- Result buffer: holds the previous results until overwritten during UNLOAD. result_valid=0 while busy.
- Arithmetic: no arithmetic is done in this block. The result width RES_W is sufficient because 3*15*15=675 < 1024.
- Array contract: the multiplier's unload index is 0 at UNLOAD entry.

Optional Feature:
- Macro: MATSEQ_CHECKSUM_EN.
- Defined: adds output port checksum (RES_W+4 bits, registered). It is cleared at start accept, incremented by each captured C[n] during UNLOAD, and stable from DONE until the next start. Reset value is 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- W=identity, X elements 1..9, start -> done 15 cycles after the accept edge (SETTLE=1); C reads 1..9; mm_clear=1FF for 1 cycle, then mm_load=1FF for 3 cycles.
- All W and X elements = 15 -> every C[n]=675; result_valid=1 after done; rd_addr=9 gives rd_data=0.
- During FEED check operands: cycle k=1 gives mm_w2=W[1][1] and mm_x3=X[1][2], compared against a model.
- start re-pulsed and wr_en issued while busy -> ignored; run length unchanged; W/X unchanged, verified by a second run.
- rst asserted in FEED cycle k=1 -> next cycle all mm_* outputs=0 and busy=0; no done pulse; C reads 0.
- With MATSEQ_CHECKSUM_EN, all elements 15 -> checksum=6075. With W=0 -> checksum=0.
